ps2_key_rx: RTL

PS2_KEY_RX -- requirements
Module: ps2_key_rx

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_frame_rx.sv | 128 ++++++++++++
 rtl/ps2_key_rx.sv | 67 ++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 keyboard receiver.
// Holds the frame-state encoding and the scan-code prefix/discard bytes.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E1 = 8'hE1;

    // Bytes following an E1 that belong to the pause sequence
    localparam int E1_SKIP = 7;

    // Acknowledge/status bytes that never form a key event
    localparam int DISCARD_N = 6;
    localparam logic [7:0] DISCARD_LIST [DISCARD_N] =
        '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    function automatic logic is_discard(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < DISCARD_N; i++) begin
            if (b == DISCARD_LIST[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes and deglitches the device clock, then
// assembles start/8 data/odd parity/stop frames into bytes with a watchdog.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILT    = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_stb,
    output logic       rx_err
);

    localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    // NOTE: registered state always uses non-blocking assignments so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            fall     <= 1'b0;
            // Filtered clock follows only after FILT consecutive differing samples
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILT - 1)) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
                fall     <= ~clk_sync[1];
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    frame_state_t  state, state_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic          perr, perr_nxt;
    logic [TW-1:0] tmo, tmo_nxt;
    logic          load;
    logic          err;

    always_ff @(posedge clk_sys) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        perr_nxt    = perr;
        tmo_nxt     = '0;
        load        = 1'b0;
        err         = 1'b0;
        if (state != ST_IDLE && !fall) tmo_nxt = tmo + 1'b1;
        if (fall) begin
            case (state)
                ST_IDLE: begin
                    if (!dat_sync[1]) begin
                        state_nxt   = ST_DATA;
                        bit_cnt_nxt = '0;
                        perr_nxt    = 1'b0;
                    end
                end
                ST_DATA: begin
                    shift_nxt   = {dat_sync[1], shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
                end
                ST_PARITY: begin
                    perr_nxt  = ~(^{shift, dat_sync[1]});
                    state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    if (dat_sync[1] && !perr) load = 1'b1;
                    else                      err  = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end else if (state != ST_IDLE && tmo == TW'(TIMEOUT - 1)) begin
            err       = 1'b1;
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            shift   <= '0;
            bit_cnt <= '0;
            perr    <= 1'b0;
            tmo     <= '0;
            rx_byte <= '0;
            rx_stb  <= 1'b0;
            rx_err  <= 1'b0;
        end else begin
            shift   <= shift_nxt;
            bit_cnt <= bit_cnt_nxt;
            perr    <= perr_nxt;
            tmo     <= tmo_nxt;
            rx_stb  <= load;
            rx_err  <= err;
            if (load) rx_byte <= shift;
        end
    end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver top: frame reception plus scan-code set 2 decoding
// into a toggle-flagged key event word.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int FILT    = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic [7:0]  rx_byte,
    output logic        rx_stb,
    output logic        rx_err
);

    ps2_frame_rx #(
        .FILT    (FILT),
        .TIMEOUT (TIMEOUT)
    ) u_frame (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .rx_stb   (rx_stb),
        .rx_err   (rx_err)
    );

    logic       ext;
    logic       rel;
    logic [2:0] skip;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ext     <= 1'b0;
            rel     <= 1'b0;
            skip    <= '0;
            ps2_key <= '0;
        end else if (rx_err) begin
            ext  <= 1'b0;
            rel  <= 1'b0;
            skip <= '0;
        end else if (rx_stb) begin
            if (skip != '0) begin
                skip <= skip - 1'b1;
            end else if (rx_byte == BYTE_E1) begin
                skip <= 3'(E1_SKIP);
            end else if (rx_byte == BYTE_E0) begin
                ext <= 1'b1;
            end else if (rx_byte == BYTE_F0) begin
                rel <= 1'b1;
            end else if (is_discard(rx_byte)) begin
                ext <= 1'b0;
                rel <= 1'b0;
            end else begin
                // Whole word updates at once; consumers watch bit 10 for events
                ps2_key <= {~ps2_key[10], ~rel, ext, rx_byte};
                ext     <= 1'b0;
                rel     <= 1'b0;
            end
        end
    end

endmodule
